// File: rtl/fft_result_unloader.sv
// fft_result_unloader: captures a full FFT result frame on fft_done and
// streams it out one sample per beat over a valid/ready interface.
// The snapshot is private, so the FFT core may start a new frame as soon
// as the capture edge has passed.
module fft_result_unloader #(
  parameter int NUM_SAMPLES = 512,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 9
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fft_done,
  input  logic [NUM_SAMPLES-1:0][DATA_W-1:0]  all_data,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [IDX_W-1:0]                    out_index,
  output logic                                out_last,
  output logic                                busy,
  output logic                                unload_done,
  output logic                                overrun,
  input  logic                                clear_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                             state;
  logic [IDX_W-1:0]                   idx;
  logic [IDX_W-1:0]                   idx_nxt;
  logic [NUM_SAMPLES-1:0][DATA_W-1:0] snap;
  logic                               capture;

  // FINISH accepts a new frame just like IDLE, so back-to-back frames lose no cycle.
  assign capture = fft_done && (state != STREAM);
  assign idx_nxt = idx + 1'b1;

  // Snapshot buffer: plain storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (capture) snap <= all_data;
  end

  // Unload FSM; every output is registered and tracks idx in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      out_data    <= '0;
      out_index   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      unload_done <= 1'b0;
    end else begin
      unload_done <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (fft_done) begin
            // Sample 0 comes straight from the bus; snap loads on this same edge.
            state     <= STREAM;
            idx       <= '0;
            out_index <= '0;
            out_data  <= all_data[0];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= (LAST_IDX == '0);
          end else begin
            state <= IDLE;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state       <= FINISH;
              out_valid   <= 1'b0;
              busy        <= 1'b0;
              out_last    <= 1'b0;
              unload_done <= 1'b1;
            end else begin
              idx       <= idx_nxt;
              out_index <= idx_nxt;
              out_data  <= snap[idx_nxt];
              out_last  <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun: a frame pulse while streaming is dropped but flagged; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           overrun <= 1'b0;
    else if (fft_done && state == STREAM) overrun <= 1'b1;
    else if (clear_overrun)            overrun <= 1'b0;
  end

endmodule

// File: tb/tb_fft_result_unloader.sv
// tb_fft_result_unloader: directed bench for fft_result_unloader.
// Inputs are driven and outputs sampled on the falling edge of tb_clk.
module tb_fft_result_unloader;
  localparam int N  = 512;
  localparam int DW = 16;
  localparam int IW = 9;

  logic                  tb_clk = 1'b0;
  logic                  rst, fft_done, out_ready, clear_overrun;
  logic [N-1:0][DW-1:0]  all_data;
  logic [DW-1:0]         out_data;
  logic [IW-1:0]         out_index;
  logic                  out_valid, out_last, busy, unload_done, overrun;
  logic [63:0]           obs;

  int n_cmp = 0;
  int n_err = 0;
  int acc;

  typedef struct {
    logic          rdy;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;
  vec_t tbl [10];

  fft_result_unloader #(.NUM_SAMPLES(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(tb_clk), .rst(rst), .fft_done(fft_done), .all_data(all_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .unload_done(unload_done), .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 tb_clk = ~tb_clk;

  assign obs = {36'd0, out_valid, out_index, out_data, out_last, busy};

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge tb_clk);
  endtask

  function automatic logic [63:0] beat(input int b, input logic [DW-1:0] d);
    return {36'd0, 1'b1, IW'(b), d, (b == N-1), 1'b1};
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) all_data[i] = DW'(i);
  endtask

  task automatic fill_const(input logic [DW-1:0] k);
    for (int i = 0; i < N; i++) all_data[i] = k;
  endtask

  // Expects to be called at the falling edge showing beat 'from', out_ready held 1.
  task automatic check_beats(input string nm, input int from, input int to,
                             input bit ramp, input logic [DW-1:0] k);
    for (int b = from; b <= to; b++) begin
      chk(nm, obs, beat(b, ramp ? DW'(b) : k));
      tick();
    end
  endtask

  initial begin
    // ready pattern 1,0,0,1 repeating; index advances only after accepted beats
    tbl[0] = '{1'b1, 9'd0, 16'h0001, 1'b0};
    tbl[1] = '{1'b0, 9'd1, 16'h0001, 1'b0};
    tbl[2] = '{1'b0, 9'd1, 16'h0001, 1'b0};
    tbl[3] = '{1'b1, 9'd1, 16'h0001, 1'b0};
    tbl[4] = '{1'b1, 9'd2, 16'h0001, 1'b0};
    tbl[5] = '{1'b0, 9'd3, 16'h0001, 1'b0};
    tbl[6] = '{1'b0, 9'd3, 16'h0001, 1'b0};
    tbl[7] = '{1'b1, 9'd3, 16'h0001, 1'b0};
    tbl[8] = '{1'b1, 9'd4, 16'h0001, 1'b0};
    tbl[9] = '{1'b0, 9'd5, 16'h0001, 1'b0};

    rst = 1'b1; fft_done = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0;
    fill_ramp();
    tick(); tick();
    chk("reset_flags", 64'({out_valid, out_last, busy, unload_done, overrun}), 64'd0);
    chk("reset_data", 64'({out_index, out_data}), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 64'({out_valid, busy}), 64'd0);

    // Ramp frame, ready high; bus overwritten right after capture.
    out_ready = 1'b1; fft_done = 1'b1; tick(); fft_done = 1'b0;
    fill_const(16'hFFFF);
    check_beats("ramp_beat", 0, N-1, 1'b1, 16'h0);
    chk("ramp_unload_done", 64'({unload_done, out_valid, busy}), 64'b100);
    tick();
    chk("ramp_idle", 64'({unload_done, out_valid, busy}), 64'd0);

    // Backpressure: table for the opening cycles, then the same pattern to the end.
    fill_const(16'h0001); out_ready = 1'b0; fft_done = 1'b1; tick(); fft_done = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = tbl[c].rdy;
      chk("bp_vec", obs, {36'd0, 1'b1, tbl[c].idx, tbl[c].data, tbl[c].last, 1'b1});
      if (tbl[c].rdy) acc++;
      tick();
    end
    for (int c = 10; acc < N && c < 3000; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      chk("bp_beat", obs, beat(acc, 16'h0001));
      if (out_ready) acc++;
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'(N));
    chk("bp_unload_done", 64'({unload_done, out_valid}), 64'b10);
    out_ready = 1'b1;
    tick();

    // Overrun: second pulse at beat 100 is flagged and ignored; set beats clear at 200.
    fill_ramp(); fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_beats("ovr_beat", 0, 99, 1'b1, 16'h0);
    chk("ovr_pre", 64'(overrun), 64'd0);
    fill_const(16'hFFFF); fft_done = 1'b1;
    chk("ovr_beat", obs, beat(100, 16'd100));
    tick(); fft_done = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    check_beats("ovr_beat", 101, 199, 1'b1, 16'h0);
    fft_done = 1'b1; clear_overrun = 1'b1;
    chk("ovr_beat", obs, beat(200, 16'd200));
    tick(); fft_done = 1'b0; clear_overrun = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    check_beats("ovr_beat", 201, N-1, 1'b1, 16'h0);
    chk("ovr_unload_done", 64'({unload_done, out_valid}), 64'b10);
    tick(); tick();
    chk("ovr_no_restart", 64'({out_valid, busy, overrun}), 64'b001);
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);

    // Back-to-back: new frame accepted in the FINISH cycle.
    fill_ramp(); fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_beats("b2b_beat", 0, N-1, 1'b1, 16'h0);
    chk("b2b_unload_done", 64'({unload_done, out_valid}), 64'b10);
    fill_const(16'hA5A5); fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk("b2b_restart", 64'({unload_done, out_valid, out_index, out_data}),
        64'({1'b0, 1'b1, 9'd0, 16'hA5A5}));
    check_beats("b2b2_beat", 0, N-1, 1'b0, 16'hA5A5);
    chk("b2b2_unload_done", 64'({unload_done, out_valid}), 64'b10);
    tick();

    // Asynchronous reset mid-stream at beat 300.
    fill_ramp(); fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_beats("rst_beat", 0, 299, 1'b1, 16'h0);
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'({out_valid, busy, out_last}), 64'd0);
    tick(); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_idle", 64'({out_valid, busy, unload_done}), 64'd0);
    end
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_beats("rst_restart", 0, N-1, 1'b1, 16'h0);
    chk("rst_unload_done", 64'({unload_done, out_valid}), 64'b10);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_result_unloader.md
Name: fft_result_unloader

Overview:
- Reader-side counterpart of the FFT input setup block: captures the full 512-point result array when the FFT signals done, then streams it out one sample per beat over a valid/ready interface.
- Sits between the FFT core's parallel result bus and the downstream serial consumer (output FIFO / host interface).
- Holds its own snapshot, so the FFT core may start a new frame as soon as capture completes.

Parameters:
- NUM_SAMPLES, 512, number of samples per frame.
- DATA_W, 16, bits per sample.
- IDX_W, 9, index width, equal to clog2(NUM_SAMPLES).

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fft_done  input  1  one-cycle pulse: all_data holds a valid frame this cycle.
- all_data  input  NUM_SAMPLES x DATA_W  packed FFT result array; element i is sample i.
- out_data  output  DATA_W  current sample being offered.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both 1.
- out_index  output  IDX_W  index of the sample on out_data.
- out_last  output  1  high with the beat for index NUM_SAMPLES-1.
- busy  output  1  frame held and not fully drained.
- unload_done  output  1  one-cycle pulse after the last beat is accepted.
- overrun  output  1  sticky: fft_done arrived while busy.
- clear_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the index goes to 0.
  - out_valid, out_last, busy, unload_done and overrun all go to 0.
  - out_data and out_index go to 0.
  - The snapshot buffer is not reset.
- States: IDLE, STREAM, FINISH.
- IDLE:
  - out_valid=0, busy=0.
  - On fft_done=1, snapshot all_data into the internal buffer, set idx=0 and go to STREAM.
- STREAM:
  - out_valid=1, busy=1, out_data=buf[idx], out_index=idx, out_last=(idx==NUM_SAMPLES-1).
  - All three outputs are registered and reflect idx in the same cycle.
  - On a handshake with idx<NUM_SAMPLES-1: idx increments and the next sample appears the following cycle.
  - On a handshake with idx==NUM_SAMPLES-1: go to FINISH.
  - Without a handshake: all outputs hold stable (no data change while valid and not ready).
- FINISH (exactly one cycle):
  - out_valid=0, busy=0, unload_done=1, then return to IDLE.
  - fft_done in this cycle is accepted as a new capture (same as IDLE). The next state is then STREAM, not IDLE, and unload_done still pulses.
- Latency:
  - fft_done sampled at edge k gives out_valid=1 with sample 0 after edge k.
  - With out_ready held at 1, a frame drains in NUM_SAMPLES cycles. unload_done is high in the cycle after the last beat.
- Overrun:
  - fft_done=1 in STREAM sets overrun=1.
  - The pulse is otherwise ignored: the buffer and idx are unchanged and the in-flight frame completes intact.
  - clear_overrun=1 clears overrun next edge. If set and clear occur in the same cycle, set wins.
- Index never wraps inside a frame. Each new capture always restarts at 0.
- Reset mid-STREAM: abort immediately, out_valid drops asynchronously, no unload_done pulse.
- Width rules: samples pass through bit-exact. No rounding, sign handling or reordering; bit-reversal is the FFT core's responsibility.

Test Plan:
- Ramp frame, ready always high: all_data[i]=i, pulse fft_done -> 512 beats with out_data=out_index=0..511 on consecutive cycles. out_last only on beat 511. unload_done one cycle after it. busy=0 afterwards.
- Backpressure: constant frame all_data[i]=16'h0001 (matches setup-side bench). Toggle out_ready 1,0,0,1,... -> out_data and out_index hold during ready=0. Exactly 512 accepted beats, no duplicates or skips.
- Snapshot isolation: change all_data to 16'hFFFF on the cycle after fft_done -> streamed values remain the captured ramp.
- Overrun: second fft_done at beat 100 -> overrun=1. Stream continues 100..511 unchanged. No restart after unload_done. clear_overrun -> overrun=0.
- Back-to-back: fft_done asserted in the FINISH cycle with a new frame 16'hA5A5 -> unload_done pulses, then the next cycle out_valid=1, out_index=0, out_data=16'hA5A5.
- Async reset at beat 300: assert rst between edges -> out_valid=0 and busy=0 immediately. After release the block stays idle until the next fft_done, which restarts from index 0.
